// File: rtl/frame_burst_write_ctrl.sv
// Frame writer: splits a frame from the write FIFO into memory bursts and
// rotates through a ring of frame buffers, skipping the one the reader holds.
module frame_burst_write_ctrl #(
  parameter int ADDR_BITS  = 28,
  parameter int BUSRT_BITS = 10,
  parameter int BURST_SIZE = 128,
  parameter int NUM_BUFS   = 4,
  parameter int IDX_BITS   = 2,
  parameter int CNT_BITS   = 16
) (
  input  logic                          mem_clk,
  input  logic                          rst,
  input  logic                          write_req,
  output logic                          write_req_ack,
  input  logic [ADDR_BITS-1:0]          write_len,
  input  logic [NUM_BUFS*ADDR_BITS-1:0] base_addr,
  input  logic [CNT_BITS-1:0]           rdusedw,
  output logic                          fifo_aclr,
  output logic                          wr_burst_req,
  output logic [BUSRT_BITS-1:0]         wr_burst_len,
  output logic [ADDR_BITS-1:0]          wr_burst_addr,
  input  logic                          wr_burst_finish,
  input  logic                          proc_lock,
  input  logic [IDX_BITS-1:0]           proc_lock_idx,
  output logic                          frame_done_irq,
  output logic [IDX_BITS-1:0]           frame_done_idx,
  output logic [IDX_BITS-1:0]           cur_idx,
  output logic [15:0]                   frame_cnt
);

  localparam int CMP_BITS  = (CNT_BITS > ADDR_BITS) ? CNT_BITS : ADDR_BITS;
  localparam int NUM_SLOTS = 1 << IDX_BITS;

  typedef enum logic [2:0] {IDLE, ACK, WAIT_DATA, BURST, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_BITS-1:0]    rem_reg, rem_next;
  logic [ADDR_BITS-1:0]    addr_reg, addr_next;
  logic [IDX_BITS-1:0]     cur_idx_reg, cur_idx_next;
  logic [15:0]             frame_cnt_reg, frame_cnt_next;
  logic                    burst_req_reg, burst_req_next;
  logic [BUSRT_BITS-1:0]   burst_len_reg, burst_len_next;
  logic [ADDR_BITS-1:0]    burst_addr_reg, burst_addr_next;

  logic [ADDR_BITS-1:0]    base_arr [NUM_SLOTS];
  logic [ADDR_BITS-1:0]    burst_cap;
  logic [ADDR_BITS-1:0]    blen;
  logic                    fifo_ok;
  logic [IDX_BITS-1:0]     idx_plus1, idx_plus2, idx_adv;

  // Index space is padded to a power of two so cur_idx never needs a range check.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_base
      if (gi < NUM_BUFS) begin : g_used
        assign base_arr[gi] = base_addr[gi*ADDR_BITS +: ADDR_BITS];
      end else begin : g_unused
        assign base_arr[gi] = '0;
      end
    end
  endgenerate

  assign burst_cap = ADDR_BITS'(BURST_SIZE);
  assign blen      = (rem_reg < burst_cap) ? rem_reg : burst_cap;
  assign fifo_ok   = CMP_BITS'(rdusedw) >= CMP_BITS'(blen);

  // Next buffer, hopping over the one locked by the processor.
  assign idx_plus1 = (cur_idx_reg == IDX_BITS'(NUM_BUFS - 1)) ? '0 : cur_idx_reg + IDX_BITS'(1);
  assign idx_plus2 = (idx_plus1 == IDX_BITS'(NUM_BUFS - 1)) ? '0 : idx_plus1 + IDX_BITS'(1);
  assign idx_adv   = (proc_lock && (idx_plus1 == proc_lock_idx)) ? idx_plus2 : idx_plus1;

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      rem_reg        <= '0;
      addr_reg       <= '0;
      cur_idx_reg    <= '0;
      frame_cnt_reg  <= '0;
      burst_req_reg  <= 1'b0;
      burst_len_reg  <= '0;
      burst_addr_reg <= '0;
    end else begin
      state_reg      <= state_next;
      rem_reg        <= rem_next;
      addr_reg       <= addr_next;
      cur_idx_reg    <= cur_idx_next;
      frame_cnt_reg  <= frame_cnt_next;
      burst_req_reg  <= burst_req_next;
      burst_len_reg  <= burst_len_next;
      burst_addr_reg <= burst_addr_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    rem_next        = rem_reg;
    addr_next       = addr_reg;
    cur_idx_next    = cur_idx_reg;
    frame_cnt_next  = frame_cnt_reg;
    burst_req_next  = burst_req_reg;
    burst_len_next  = burst_len_reg;
    burst_addr_next = burst_addr_reg;

    case (state_reg)
      IDLE: begin
        if (write_req) begin
          state_next = ACK;
          rem_next   = write_len;
          addr_next  = base_arr[cur_idx_reg];
        end
      end
      ACK: begin
        if (!write_req) state_next = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (rem_reg == '0) begin
          state_next = DONE;
        end else if (fifo_ok) begin
          // Burst fields are frozen here and held for the whole request.
          state_next      = BURST;
          burst_req_next  = 1'b1;
          burst_len_next  = BUSRT_BITS'(blen);
          burst_addr_next = addr_reg;
        end
      end
      BURST: begin
        if (wr_burst_finish) begin
          state_next     = WAIT_DATA;
          burst_req_next = 1'b0;
          addr_next      = addr_reg + ADDR_BITS'(burst_len_reg);
          rem_next       = rem_reg - ADDR_BITS'(burst_len_reg);
        end
      end
      DONE: begin
        state_next     = IDLE;
        frame_cnt_next = frame_cnt_reg + 16'd1;
        cur_idx_next   = idx_adv;
      end
      default: state_next = IDLE;
    endcase
  end

  assign write_req_ack  = (state_reg == ACK);
  assign fifo_aclr      = (state_reg == ACK);
  assign wr_burst_req   = burst_req_reg;
  assign wr_burst_len   = burst_len_reg;
  assign wr_burst_addr  = burst_addr_reg;
  assign frame_done_irq = (state_reg == DONE);
  assign frame_done_idx = (state_reg == DONE) ? cur_idx_reg : '0;
  assign cur_idx        = cur_idx_reg;
  assign frame_cnt      = frame_cnt_reg;

endmodule

// File: tb/tb_frame_burst_write_ctrl.sv
// Directed bench for frame_burst_write_ctrl: burst splitting, FIFO gating,
// buffer rotation with lock skip, zero-length frames, async reset, address wrap.
module tb_frame_burst_write_ctrl;

  logic         mem_clk = 1'b0;
  logic         rst;
  logic         write_req;
  logic         write_req_ack;
  logic [27:0]  write_len;
  logic [111:0] base_addr;
  logic [15:0]  rdusedw;
  logic         fifo_aclr;
  logic         wr_burst_req;
  logic [9:0]   wr_burst_len;
  logic [27:0]  wr_burst_addr;
  logic         wr_burst_finish;
  logic         proc_lock;
  logic [1:0]   proc_lock_idx;
  logic         frame_done_irq;
  logic [1:0]   frame_done_idx;
  logic [1:0]   cur_idx;
  logic [15:0]  frame_cnt;

  // Second instance with two buffers
  logic         write_req2;
  logic         write_req_ack2;
  logic [27:0]  write_len2;
  logic [55:0]  base_addr2;
  logic [15:0]  rdusedw2;
  logic         fifo_aclr2;
  logic         wr_burst_req2;
  logic [9:0]   wr_burst_len2;
  logic [27:0]  wr_burst_addr2;
  logic         wr_burst_finish2;
  logic         proc_lock2;
  logic [0:0]   proc_lock_idx2;
  logic         frame_done_irq2;
  logic [0:0]   frame_done_idx2;
  logic [0:0]   cur_idx2;
  logic [15:0]  frame_cnt2;

  always #5 mem_clk = ~mem_clk;

  frame_burst_write_ctrl dut (
    .mem_clk(mem_clk), .rst(rst), .write_req(write_req), .write_req_ack(write_req_ack),
    .write_len(write_len), .base_addr(base_addr), .rdusedw(rdusedw), .fifo_aclr(fifo_aclr),
    .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len), .wr_burst_addr(wr_burst_addr),
    .wr_burst_finish(wr_burst_finish), .proc_lock(proc_lock), .proc_lock_idx(proc_lock_idx),
    .frame_done_irq(frame_done_irq), .frame_done_idx(frame_done_idx), .cur_idx(cur_idx),
    .frame_cnt(frame_cnt)
  );

  frame_burst_write_ctrl #(.NUM_BUFS(2), .IDX_BITS(1)) dut2 (
    .mem_clk(mem_clk), .rst(rst), .write_req(write_req2), .write_req_ack(write_req_ack2),
    .write_len(write_len2), .base_addr(base_addr2), .rdusedw(rdusedw2), .fifo_aclr(fifo_aclr2),
    .wr_burst_req(wr_burst_req2), .wr_burst_len(wr_burst_len2), .wr_burst_addr(wr_burst_addr2),
    .wr_burst_finish(wr_burst_finish2), .proc_lock(proc_lock2), .proc_lock_idx(proc_lock_idx2),
    .frame_done_irq(frame_done_irq2), .frame_done_idx(frame_done_idx2), .cur_idx(cur_idx2),
    .frame_cnt(frame_cnt2)
  );

  int checks = 0;
  int errors = 0;

  logic [27:0] b_addr [8];
  logic [9:0]  b_len  [8];
  logic [27:0] b_addr_late [8];
  logic [9:0]  b_len_late  [8];
  logic        b_req_late  [8];
  int          nb;
  logic        irq_seen;
  logic [1:0]  done_idx;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_frame(input logic [27:0] len);
    int t;
    write_len = len;
    write_req = 1'b1;
    t = 0;
    do begin
      @(negedge mem_clk);
      t++;
    end while (!write_req_ack && t < 20);
    check("ack", write_req_ack, 1);
    check("fifo_aclr", fifo_aclr, 1);
    write_req = 1'b0;
  endtask

  // Plays the memory controller: holds each burst a few cycles, then pulses finish.
  task automatic run_bursts();
    int t;
    nb = 0;
    irq_seen = 1'b0;
    done_idx = '0;
    t = 0;
    while (!irq_seen && t < 500) begin
      @(negedge mem_clk);
      t++;
      if (frame_done_irq) begin
        irq_seen = 1'b1;
        done_idx = frame_done_idx;
      end else if (wr_burst_req) begin
        if (nb < 8) begin
          b_addr[nb] = wr_burst_addr;
          b_len[nb]  = wr_burst_len;
        end
        repeat (2) @(negedge mem_clk);
        if (nb < 8) begin
          b_addr_late[nb] = wr_burst_addr;
          b_len_late[nb]  = wr_burst_len;
          b_req_late[nb]  = wr_burst_req;
        end
        nb++;
        wr_burst_finish = 1'b1;
        @(negedge mem_clk);
        wr_burst_finish = 1'b0;
      end
    end
    check("irq_seen", irq_seen, 1);
    @(negedge mem_clk);
    check("irq_one_cycle", frame_done_irq, 0);
  endtask

  task automatic check_burst(input int i, input logic [27:0] a, input logic [9:0] l);
    check($sformatf("burst%0d_addr", i), b_addr[i], a);
    check($sformatf("burst%0d_len", i), b_len[i], l);
    check($sformatf("burst%0d_addr_held", i), b_addr_late[i], a);
    check($sformatf("burst%0d_len_held", i), b_len_late[i], l);
    check($sformatf("burst%0d_req_held", i), b_req_late[i], 1);
  endtask

  task automatic frame_result(input int exp_nb, input logic [1:0] exp_done,
                              input logic [1:0] exp_cur, input logic [15:0] exp_cnt);
    check("burst_count", nb, exp_nb);
    check("done_idx", done_idx, exp_done);
    check("cur_idx", cur_idx, exp_cur);
    check("frame_cnt", frame_cnt, exp_cnt);
    $display("frame: bursts=%0d done_idx=%0d cur_idx=%0d frame_cnt=%0d", nb, done_idx, cur_idx, frame_cnt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    logic flag;
    rst = 1'b1;
    write_req = 0; write_len = '0; rdusedw = 16'd512; wr_burst_finish = 0;
    proc_lock = 0; proc_lock_idx = '0;
    base_addr = {28'h4000, 28'h3000, 28'h2000, 28'h100};
    write_req2 = 0; write_len2 = '0; base_addr2 = {28'h20, 28'h10}; rdusedw2 = 16'd512;
    wr_burst_finish2 = 0; proc_lock2 = 0; proc_lock_idx2 = '0;
    repeat (3) @(negedge mem_clk);
    check("rst_ack", write_req_ack, 0);
    check("rst_aclr", fifo_aclr, 0);
    check("rst_req", wr_burst_req, 0);
    check("rst_irq", frame_done_irq, 0);
    check("rst_cur", cur_idx, 0);
    check("rst_cnt", frame_cnt, 0);
    rst = 1'b0;
    @(negedge mem_clk);

    // 300 words in 128-word bursts
    start_frame(28'd300);
    run_bursts();
    check_burst(0, 28'h100, 10'd128);
    check_burst(1, 28'h180, 10'd128);
    check_burst(2, 28'h200, 10'd44);
    frame_result(3, 2'd0, 2'd1, 16'd1);

    // Burst held off until the FIFO holds a full burst
    rdusedw = 16'd100;
    start_frame(28'd128);
    flag = 1'b0;
    repeat (10) begin
      @(negedge mem_clk);
      if (wr_burst_req) flag = 1'b1;
    end
    check("no_req_low_fifo", flag, 0);
    rdusedw = 16'd128;
    @(negedge mem_clk);
    check("req_after_fifo", wr_burst_req, 1);
    run_bursts();
    check_burst(0, 28'h2000, 10'd128);
    frame_result(1, 2'd1, 2'd2, 16'd2);
    rdusedw = 16'd512;

    start_frame(28'd5);
    run_bursts();
    check_burst(0, 28'h3000, 10'd5);
    frame_result(1, 2'd2, 2'd3, 16'd3);

    start_frame(28'd129);
    run_bursts();
    check_burst(0, 28'h4000, 10'd128);
    check_burst(1, 28'h4080, 10'd1);
    frame_result(2, 2'd3, 2'd0, 16'd4);

    // Zero-length frame
    start_frame(28'd0);
    run_bursts();
    frame_result(0, 2'd0, 2'd1, 16'd5);

    // Lock skip: from 1, buffer 2 locked -> 3
    proc_lock = 1'b1; proc_lock_idx = 2'd2;
    start_frame(28'd0);
    run_bursts();
    frame_result(0, 2'd1, 2'd3, 16'd6);

    // Lock index matches but lock inactive -> no skip
    proc_lock = 1'b0; proc_lock_idx = 2'd0;
    start_frame(28'd0);
    run_bursts();
    frame_result(0, 2'd3, 2'd0, 16'd7);

    proc_lock = 1'b1; proc_lock_idx = 2'd1;
    start_frame(28'd0);
    run_bursts();
    frame_result(0, 2'd0, 2'd2, 16'd8);
    proc_lock = 1'b0;

    // Two buffers, buffer 1 locked: index stays 0
    proc_lock2 = 1'b1; proc_lock_idx2 = 1'b1;
    write_req2 = 1'b1;
    t = 0;
    do begin @(negedge mem_clk); t++; end while (!write_req_ack2 && t < 20);
    check("dut2_ack", write_req_ack2, 1);
    write_req2 = 1'b0;
    t = 0;
    do begin @(negedge mem_clk); t++; end while (!frame_done_irq2 && t < 20);
    check("dut2_irq", frame_done_irq2, 1);
    check("dut2_done_idx", frame_done_idx2, 0);
    @(negedge mem_clk);
    check("dut2_cur", cur_idx2, 0);
    check("dut2_cnt", frame_cnt2, 1);
    $display("dut2 frame: cur_idx=%0d frame_cnt=%0d", cur_idx2, frame_cnt2);

    // Reset in the middle of a burst
    start_frame(28'd300);
    t = 0;
    do begin @(negedge mem_clk); t++; end while (!wr_burst_req && t < 20);
    check("pre_rst_req", wr_burst_req, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_req", wr_burst_req, 0);
    check("rst_mid_cur", cur_idx, 0);
    check("rst_mid_cnt", frame_cnt, 0);
    check("rst_mid_irq", frame_done_irq, 0);
    @(negedge mem_clk);
    rst = 1'b0;
    flag = 1'b0;
    repeat (6) begin
      @(negedge mem_clk);
      if (wr_burst_req || frame_done_irq) flag = 1'b1;
    end
    check("rst_quiet", flag, 0);
    $display("reset mid-burst: cur_idx=%0d frame_cnt=%0d", cur_idx, frame_cnt);

    // Address wraps modulo 2^28
    base_addr[27:0] = 28'hFFFFFC0;
    start_frame(28'd200);
    run_bursts();
    check_burst(0, 28'hFFFFFC0, 10'd128);
    check_burst(1, 28'h0000040, 10'd72);
    frame_result(2, 2'd0, 2'd1, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_burst_write_ctrl.md
FRAME_BURST_WRITE_CTRL -- requirements
Module: frame_burst_write_ctrl

Interface
REQ-001 SHALL take parameter ADDR_BITS, default 28, memory word address width.
REQ-002 SHALL take parameter BUSRT_BITS, default 10, burst length width.
REQ-003 SHALL take parameter BURST_SIZE, default 128, maximum words per burst (1..2^BUSRT_BITS-1).
REQ-004 SHALL take parameter NUM_BUFS, default 4, frame buffer count (2..16).
REQ-005 SHALL take parameter IDX_BITS, default 2, buffer index width (>= clog2(NUM_BUFS)).
REQ-006 SHALL take parameter CNT_BITS, default 16, FIFO level width.
REQ-007 SHALL have one clock and an asynchronous, active-high reset: mem_clk  in  1  sole clock, all logic on rising edge.
REQ-008 rst  in  1  asynchronous active-high reset.
REQ-009 write_req  in  1  frame write request, held high until write_req_ack.
REQ-010 write_req_ack  out  1  request accepted.
REQ-011 write_len  in  ADDR_BITS  frame length in memory words.
REQ-012 base_addr  in  NUM_BUFS*ADDR_BITS  base address of buffer k in bits [k*ADDR_BITS +: ADDR_BITS].
REQ-013 rdusedw  in  CNT_BITS  words available in write FIFO (read side).
REQ-014 fifo_aclr  out  1  write FIFO clear.
REQ-015 wr_burst_req / wr_burst_len / wr_burst_addr  out  1 / BUSRT_BITS / ADDR_BITS  burst request to memory controller.
REQ-016 wr_burst_finish  in  1  one-cycle pulse, burst complete.
REQ-017 proc_lock / proc_lock_idx  in  1 / IDX_BITS  buffer currently owned by the data processor.
REQ-018 frame_done_irq / frame_done_idx  out  1 / IDX_BITS  frame-complete pulse and buffer written.
REQ-019 cur_idx / frame_cnt  out  IDX_BITS / 16  buffer being written; completed frame count (wraps 0xFFFF->0).

Function
REQ-020 FSM states SHALL be IDLE, ACK, WAIT_DATA, BURST, DONE.
REQ-021 IDLE: write_req=1 -> ACK next cycle; latch rem=write_len, addr=base_addr[cur_idx].
REQ-022 ACK: write_req_ack=1 and fifo_aclr=1; stay until write_req=0, then WAIT_DATA.
REQ-023 WAIT_DATA: rem=0 -> DONE; else blen=min(rem,BURST_SIZE); rdusedw>=blen -> BURST, wr_burst_len=blen, wr_burst_addr=addr, registered.
REQ-024 BURST: wr_burst_req=1 until wr_burst_finish; on finish wr_burst_req=0 same edge, addr+=blen, rem-=blen, -> WAIT_DATA.
REQ-025 Final burst SHALL be partial (rem<BURST_SIZE) without padding; write_len=0 SHALL go ACK->WAIT_DATA->DONE with no burst.
REQ-026 DONE (one cycle): frame_done_irq=1, frame_done_idx=cur_idx, frame_cnt+=1, cur_idx advances, -> IDLE.
REQ-027 Advance: nxt=(cur_idx+1) mod NUM_BUFS; if proc_lock=1 and nxt=proc_lock_idx, nxt=(nxt+1) mod NUM_BUFS; proc_lock sampled in DONE cycle only.
REQ-028 write_req outside IDLE SHALL be ignored; wr_burst_finish outside BURST SHALL be ignored.
REQ-029 Address arithmetic SHALL wrap modulo 2^ADDR_BITS.
REQ-030 Burst outputs SHALL remain stable while wr_burst_req=1.

Reset
REQ-031 rst=1 SHALL force IDLE, cur_idx=0, frame_cnt=0, all outputs 0, at any state including mid-burst; no pending burst survives.

Verification
REQ-032 write_len=300, BURST_SIZE=128, base_addr[0]=0x100, rdusedw=512 -> bursts (0x100,128),(0x180,128),(0x200,44), one frame_done_irq, idx 0.
REQ-033 rdusedw held 100 with rem=128 -> no wr_burst_req; rdusedw to 128 -> wr_burst_req next cycle.
REQ-034 Four frames, proc_lock=0 -> cur_idx 0,1,2,3,0; frame_cnt=4.
REQ-035 cur_idx=0, proc_lock=1, proc_lock_idx=1 at DONE -> cur_idx=2; NUM_BUFS=2, lock idx 1 -> cur_idx stays 0.
REQ-036 rst pulse during BURST -> wr_burst_req=0 immediately, cur_idx=0, frame_cnt=0, no irq.
REQ-037 write_len=0 -> write_req_ack, fifo_aclr, no burst, frame_done_irq one cycle.
